// File: rtl/lcd_pkg.sv
// Shared constants for the LCD pattern generator: pattern codes, colour-bar table
// and the per-channel width helper.
package lcd_pkg;

   localparam logic [1:0] MODE_BARS  = 2'd0;
   localparam logic [1:0] MODE_RAMP  = 2'd1;
   localparam logic [1:0] MODE_CHECK = 2'd2;
   localparam logic [1:0] MODE_MOVE  = 2'd3;

   localparam int COORD_W = 16;

   // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

   function automatic int chan_w(input int data_w, input int subpix);
      return (subpix == 1) ? data_w / 3 : data_w;
   endfunction

endpackage

// File: rtl/lcd_pattern_rgb.sv
// Combinational test-pattern colour for one pixel coordinate, CW bits per channel.
// Zero latency; no flow control.
module lcd_pattern_rgb
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 320,
   parameter int CW       = 8
)(
   input  logic [1:0]         i_mode,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic [7:0]         i_frame_cnt,
   output logic [3*CW-1:0]    o_rgb
);

   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [2:0]    w_bar_idx;
   logic [2:0]    w_mask;
   logic [7:0]    w_move;
   logic [CW-1:0] w_ramp;
   wire           w_unused = &{1'b0, i_y[COORD_W-1:5], i_y[3:0]};

   always_comb begin
      w_bar_idx = 3'd0;
      // Last bar keeps everything past 7*BAR_W, absorbing the remainder.
      for (int i = 1; i < 8; i++) begin
         if (32'(i_x) >= 32'(i * BAR_W)) w_bar_idx = 3'(i);
      end
      w_move = i_x[7:0] - i_frame_cnt;
      w_ramp = i_x[CW-1:0];
      w_mask = 3'b000;
      case (i_mode)
         MODE_BARS:  w_mask = BAR_RGB[w_bar_idx];
         MODE_CHECK: w_mask = (i_x[4] ^ i_y[4]) ? 3'b111 : 3'b000;
         MODE_MOVE:  w_mask = (w_move < 8'd16) ? 3'b111 : 3'b001;
         default:    w_mask = 3'b000;
      endcase
      if (i_mode == MODE_RAMP) o_rgb = {w_ramp, w_ramp, w_ramp};
      else                     o_rgb = {{CW{w_mask[2]}}, {CW{w_mask[1]}}, {CW{w_mask[0]}}};
   end

endmodule

// File: rtl/lcd_pattern_gen.sv
// LCD raster timing plus test-pattern driver, serial (3 clk/pixel) or parallel RGB.
// All outputs registered, one cycle behind the counter state they decode.
module lcd_pattern_gen
   import lcd_pkg::*;
#(
   parameter int   H_ACTIVE = 320,
   parameter int   H_FP     = 20,
   parameter int   H_SYNC   = 30,
   parameter int   H_BP     = 38,
   parameter int   V_ACTIVE = 240,
   parameter int   V_FP     = 4,
   parameter int   V_SYNC   = 3,
   parameter int   V_BP     = 15,
   parameter int   DATA_W   = 8,
   parameter int   SUBPIX   = 3,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] lcd_dat,
   output logic              lcd_hsync,
   output logic              lcd_vsync,
   output logic              lcd_den,
   output logic              frame_start,
   output logic [7:0]        frame_cnt
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W  = $clog2(H_TOT);
   localparam int VC_W  = $clog2(V_TOT);
   localparam int SP_W  = (SUBPIX > 1) ? $clog2(SUBPIX) : 1;
   localparam int CW    = chan_w(DATA_W, SUBPIX);

   logic [SP_W-1:0] r_sp;
   logic [HC_W-1:0] r_hc;
   logic [VC_W-1:0] r_vc;
   logic [1:0]      r_mode_q;

   logic [COORD_W-1:0] w_x, w_y;
   logic [3*CW-1:0]    w_rgb;
   logic [DATA_W-1:0]  w_dat;

   wire w_sp_wrap = (r_sp == SP_W'(SUBPIX - 1));
   wire w_hc_wrap = (r_hc == HC_W'(H_TOT - 1));
   wire w_vc_wrap = (r_vc == VC_W'(V_TOT - 1));
   wire w_fs      = (r_sp == '0) && (r_hc == '0) && (r_vc == '0);
   wire w_den     = (32'(r_hc) < 32'(H_ACTIVE)) && (32'(r_vc) < 32'(V_ACTIVE));
   wire w_hs_act  = (32'(r_hc) >= 32'(H_ACTIVE + H_FP)) &&
                    (32'(r_hc) <  32'(H_ACTIVE + H_FP + H_SYNC));
   wire w_vs_act  = (32'(r_vc) >= 32'(V_ACTIVE + V_FP)) &&
                    (32'(r_vc) <  32'(V_ACTIVE + V_FP + V_SYNC));

   // First pixel of a frame already uses the new mode/count so a frame never mixes patterns.
   wire [1:0] w_mode_eff = w_fs ? mode : r_mode_q;
   wire [7:0] w_fcnt_eff = w_fs ? frame_cnt + 8'd1 : frame_cnt;

   assign w_x = COORD_W'(r_hc);
   assign w_y = COORD_W'(r_vc);

   lcd_pattern_rgb #(
      .H_ACTIVE (H_ACTIVE),
      .CW       (CW)
   ) u_rgb (
      .i_mode      (w_mode_eff),
      .i_x         (w_x),
      .i_y         (w_y),
      .i_frame_cnt (w_fcnt_eff),
      .o_rgb       (w_rgb)
   );

   always_comb begin
      w_dat = '0;
      if (w_den) begin
         if (SUBPIX == 1)              w_dat = DATA_W'(w_rgb);
         else if (r_sp == '0)          w_dat = DATA_W'(w_rgb[2*CW +: CW]);
         else if (r_sp == SP_W'(1))    w_dat = DATA_W'(w_rgb[CW +: CW]);
         else                          w_dat = DATA_W'(w_rgb[0 +: CW]);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sp        <= '0;
         r_hc        <= '0;
         r_vc        <= '0;
         r_mode_q    <= '0;
         lcd_dat     <= '0;
         lcd_den     <= 1'b0;
         lcd_hsync   <= ~HS_POL;
         lcd_vsync   <= ~VS_POL;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else if (!enable) begin
         r_sp        <= '0;
         r_hc        <= '0;
         r_vc        <= '0;
         lcd_dat     <= '0;
         lcd_den     <= 1'b0;
         lcd_hsync   <= ~HS_POL;
         lcd_vsync   <= ~VS_POL;
         frame_start <= 1'b0;
      end else begin
         if (w_sp_wrap) begin
            r_sp <= '0;
            if (w_hc_wrap) begin
               r_hc <= '0;
               r_vc <= w_vc_wrap ? '0 : r_vc + 1'b1;
            end else begin
               r_hc <= r_hc + 1'b1;
            end
         end else begin
            r_sp <= r_sp + 1'b1;
         end
         lcd_dat     <= w_dat;
         lcd_den     <= w_den;
         lcd_hsync   <= w_hs_act ? HS_POL : ~HS_POL;
         lcd_vsync   <= w_vs_act ? VS_POL : ~VS_POL;
         frame_start <= w_fs;
         if (w_fs) begin
            r_mode_q  <= mode;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Randomised enable/mode/reset stimulus on a serial and a parallel instance,
// both compared cycle by cycle against a raster model built from frame arithmetic.
module tb_lcd_pattern_gen;

   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   // white, yellow, cyan, green, magenta, red, blue, black as {R,G,B}
   localparam logic [2:0] BAR_COL [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] mode = 2'd0;

   logic [7:0]  d0_dat;
   logic        d0_hs, d0_vs, d0_den, d0_fs;
   logic [7:0]  d0_fc;
   logic [23:0] d1_dat;
   logic        d1_hs, d1_vs, d1_den, d1_fs;
   logic [7:0]  d1_fc;

   int n_checks = 0;
   int n_fail   = 0;

   int          m_t    [2];
   logic [1:0]  m_mode [2];
   logic [7:0]  m_fcnt [2];
   logic [23:0] e_dat  [2];
   logic        e_hs [2], e_vs [2], e_den [2], e_fs [2];
   logic [7:0]  e_fc [2];

   always #5 clk = ~clk;

   lcd_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .DATA_W(8), .SUBPIX(3), .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_dut_ser (
      .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
      .lcd_dat(d0_dat), .lcd_hsync(d0_hs), .lcd_vsync(d0_vs), .lcd_den(d0_den),
      .frame_start(d0_fs), .frame_cnt(d0_fc)
   );

   lcd_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .DATA_W(24), .SUBPIX(1), .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_dut_par (
      .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
      .lcd_dat(d1_dat), .lcd_hsync(d1_hs), .lcd_vsync(d1_vs), .lcd_den(d1_den),
      .frame_start(d1_fs), .frame_cnt(d1_fc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [23:0] ref_rgb(input logic [1:0] md, input int x, input int y,
                                           input logic [7:0] fc);
      int         idx;
      logic [2:0] m;
      logic [7:0] d;
      logic [7:0] xb;
      xb = 8'(x);
      m  = 3'b000;
      case (md)
         2'd0: begin
            idx = x / (HA / 8);
            if (idx > 7) idx = 7;
            m = BAR_COL[idx];
         end
         2'd1: return {xb, xb, xb};
         2'd2: m = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 3'b111 : 3'b000;
         default: begin
            d = xb - fc;
            m = (d < 8'd16) ? 3'b111 : 3'b001;
         end
      endcase
      return {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   // Position is derived from the number of enabled cycles since the frame began.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int sub, p, s, hc, vc;
         logic pol;
         logic [23:0] rgb;
         sub = (k == 0) ? 3 : 1;
         pol = (k == 1);
         if (!resetn || !enable) begin
            if (!resetn) begin
               m_mode[k] = 2'd0;
               m_fcnt[k] = 8'd0;
            end
            m_t[k]   = 0;
            e_dat[k] = '0;
            e_den[k] = 1'b0;
            e_fs[k]  = 1'b0;
            e_hs[k]  = ~pol;
            e_vs[k]  = ~pol;
            e_fc[k]  = m_fcnt[k];
         end else begin
            s  = m_t[k] % sub;
            p  = m_t[k] / sub;
            hc = p % HT;
            vc = p / HT;
            e_fs[k] = (m_t[k] == 0);
            if (e_fs[k]) begin
               m_mode[k] = mode;
               m_fcnt[k] = m_fcnt[k] + 8'd1;
            end
            e_fc[k]  = m_fcnt[k];
            e_den[k] = (hc < HA) && (vc < VA);
            e_hs[k]  = (hc >= HA + HF && hc < HA + HF + HS) ? pol : ~pol;
            e_vs[k]  = (vc >= VA + VF && vc < VA + VF + VS) ? pol : ~pol;
            rgb = ref_rgb(m_mode[k], hc, vc, m_fcnt[k]);
            if (!e_den[k])     e_dat[k] = '0;
            else if (sub == 1) e_dat[k] = rgb;
            else               e_dat[k] = {16'd0, rgb[23 - 8*s -: 8]};
            m_t[k] = (m_t[k] + 1) % (sub * HT * VT);
         end
      end
   end

   task automatic compare_all();
      chk("ser_dat", {24'd0, d0_dat}, e_dat[0]);
      chk("ser_hsync", d0_hs, e_hs[0]);
      chk("ser_vsync", d0_vs, e_vs[0]);
      chk("ser_den", d0_den, e_den[0]);
      chk("ser_frame_start", d0_fs, e_fs[0]);
      chk("ser_frame_cnt", d0_fc, e_fc[0]);
      chk("par_dat", d1_dat, e_dat[1]);
      chk("par_hsync", d1_hs, e_hs[1]);
      chk("par_vsync", d1_vs, e_vs[1]);
      chk("par_den", d1_den, e_den[1]);
      chk("par_frame_start", d1_fs, e_fs[1]);
      chk("par_frame_cnt", d1_fc, e_fc[1]);
   endtask

   initial begin
      int  en_low;
      bit  did_rst;
      en_low  = 0;
      did_rst = 1'b0;
      repeat (3) @(negedge clk);
      compare_all();
      resetn = 1'b1;
      enable = 1'b1;
      for (int c = 0; c < 27000; c++) begin
         @(negedge clk);
         compare_all();
         if (!did_rst && c >= 700 && e_den[0] && e_den[1]) begin
            did_rst = 1'b1;
            #2 resetn = 1'b0;
            #1;
            chk("rst_ser_den", d0_den, 1'b0);
            chk("rst_ser_dat", {24'd0, d0_dat}, 32'd0);
            chk("rst_ser_hsync", d0_hs, 1'b1);
            chk("rst_ser_vsync", d0_vs, 1'b1);
            chk("rst_ser_fcnt", d0_fc, 8'd0);
            chk("rst_par_den", d1_den, 1'b0);
            chk("rst_par_dat", d1_dat, 32'd0);
            chk("rst_par_hsync", d1_hs, 1'b0);
            chk("rst_par_vsync", d1_vs, 1'b0);
            chk("rst_par_fcnt", d1_fc, 8'd0);
            @(negedge clk);
            compare_all();
            resetn = 1'b1;
         end
         if (en_low > 0) begin
            en_low--;
            if (en_low == 0) enable = 1'b1;
         end else if ($urandom_range(0, 399) == 0) begin
            enable = 1'b0;
            en_low = $urandom_range(1, 5);
         end
         if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
